eco_patch_logic_pipe: RTL and testbench
=======================================

// Module: eco_patch_logic_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit with a runtime per-bit ECO patch layer.
//  Computes y = OP(a,b) over WIDTH lanes, then forces or inverts selected bits from patch registers.
//  Registered in-place replacement for hard-wired gate netlists plus fixed ECO gates.
//  Sits between operand producers and consumers on a valid/ready stream.
// PARAMETERS
//  WIDTH    3   lane count (bits of a, b, y); 1..64
//  STAGES   1   output pipeline depth; 1..4
//  CNT_W    16  width of the saturating patch-hit counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        operand beat valid
//  in_ready     out  1        unit can accept a beat
//  in_a         in   WIDTH    operand a
//  in_b         in   WIDTH    operand b
//  in_op        in   3        0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6 PASS_A,7 NOT_A
//  out_valid    out  1        result valid
//  out_ready    in   1        consumer accepts result
//  out_y        out  WIDTH    patched result
//  cfg_wr       in   1        write shadow patch register selected by cfg_sel
//  cfg_sel      in   2        0 EN mask, 1 VAL, 2 MODE (1 = XOR-invert, 0 = force VAL), 3 reserved (ignored)
//  cfg_data     in   WIDTH    shadow write data
//  cfg_commit   in   1        copy shadow EN/VAL/MODE into active set
//  hit_cnt      out  CNT_W    number of output beats in which the patch changed >=1 bit
//  hit_clr      in   1        synchronous clear of hit_cnt
// BEHAVIOUR
//  Reset: out_valid=0, out_y=0, hit_cnt=0, all shadow/active patch regs=0 (patch disabled); in_ready=1 after reset.
//  Raw per bit i: r[i] = OP(a[i],b[i]).
//  Patch per bit i: if EN[i]=0 then y=r; MODE[i]=0 then y=VAL[i]; MODE[i]=1 then y=r^VAL[i].
//  Patch is applied at stage 0 using the active set current at the accept cycle; in-flight beats are never re-patched.
//  Pipeline: STAGES register stages, each holding valid+data.
//  A stage loads when it is empty or its downstream stage advances. in_ready = !s0_valid | s0_advance.
//  Latency = STAGES cycles from accept to out_valid with out_ready held high. Throughput is 1 beat/cycle.
//  Stall: out_ready=0 with out_valid=1 holds out_y stable. Upstream stages fill, then in_ready drops. No beat is lost or duplicated.
//  cfg_wr: shadow updated next edge; the active set is unaffected until cfg_commit.
//  cfg_commit: active set updated at the next edge.
//    A beat accepted in the same cycle as cfg_commit uses the OLD active set.
//    cfg_wr and cfg_commit in the same cycle: the commit copies the pre-write shadow, and the write lands in the shadow only.
//  hit_cnt: +1 on each out_valid&out_ready beat whose patched y != raw r. Raw r (or a hit flag) travels down the pipe.
//    hit_cnt saturates at 2^CNT_W-1.
//    hit_clr has priority over an increment in the same cycle; the result is 0.
//  Reset mid-stream: all pipeline valids clear immediately (async). Pending beats are dropped; the config is lost.
// STRUCTURE
//  Shared package eco_pkg: op_e enum (3-bit opcodes above), cfg_sel localparams CFG_EN/CFG_VAL/CFG_MODE.
//  One sub-module: eco_pipe_stage (parametrised valid/ready register slice, data width WIDTH+1), instantiated STAGES times via generate.
//  Top holds the op decoder, patch mux, shadow/active regs and hit counter.
// TESTING
//  1 Reset, WIDTH=3, EN=0: a=000,b=000,op=NOR -> out_y=111 after 1 cycle; a=101,b=011,op=XOR -> 110; hit_cnt=0.
//  2 Force patch: shadow EN=010, VAL=000, MODE=000, commit; a=000,b=000,op=NOR -> out_y=101, hit_cnt=1.
//    a=010,b=000,op=NOR -> 101 unchanged (raw already 101), hit_cnt stays 1.
//  3 XOR patch: EN=111, VAL=001, MODE=111; a=110,b=110,op=AND -> 111; op=PASS_A with a=001 -> 000; hit_cnt +2.
//  4 Backpressure, STAGES=3: stream 8 beats, out_ready=0 for 5 cycles mid-stream -> in_ready low after 3 held beats.
//    Output order and values match the reference model; no drops or duplicates.
//  5 Commit race: cfg_commit in the same cycle as accepting beat A, beat B next -> A uses old patch, B uses new.
//  6 Saturation/clear with CNT_W=4: 20 hitting beats -> hit_cnt=15; hit_clr with a coincident hit -> 0.
//    Assert rst_n low mid-stream -> out_valid=0 same cycle, hit_cnt=0.

Source files
------------

// File: rtl/eco_pkg.sv
// eco_pkg: opcodes and patch-register selectors shared by the ECO logic pipe
package eco_pkg;
  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NAND   = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;
  localparam logic [1:0] CFG_EN   = 2'd0;
  localparam logic [1:0] CFG_VAL  = 2'd1;
  localparam logic [1:0] CFG_MODE = 2'd2;
endpackage

// File: rtl/eco_pipe_stage.sv
// eco_pipe_stage: one valid/ready register slice; loads when empty or when downstream takes its beat
module eco_pipe_stage #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  assign ready_o = !valid_q || ready_i;
  assign valid_d = ready_o ? valid_i : valid_q;
  assign data_d  = (ready_o && valid_i) ? data_i : data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/eco_patch_logic_pipe.sv
// eco_patch_logic_pipe: pipelined bitwise logic unit with a runtime per-bit ECO patch layer
module eco_patch_logic_pipe
  import eco_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_commit,
  output logic [CNT_W-1:0] hit_cnt,
  input  logic             hit_clr
);
  logic [WIDTH-1:0] sh_en_q, sh_val_q, sh_mode_q, sh_en_d, sh_val_d, sh_mode_d;
  logic [WIDTH-1:0] act_en_q, act_val_q, act_mode_q, act_en_d, act_val_d, act_mode_d;
  logic [WIDTH-1:0] raw, y;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             out_hit;
  logic             v   [STAGES+1];
  logic             rdy [STAGES+1];
  logic [WIDTH:0]   d   [STAGES+1];
  always_comb begin
    case (op_e'(in_op))
      OP_AND:    raw = in_a & in_b;
      OP_OR:     raw = in_a | in_b;
      OP_NAND:   raw = ~(in_a & in_b);
      OP_NOR:    raw = ~(in_a | in_b);
      OP_XOR:    raw = in_a ^ in_b;
      OP_XNOR:   raw = ~(in_a ^ in_b);
      OP_PASS_A: raw = in_a;
      default:   raw = ~in_a;
    endcase
  end
  // patch uses the active set registered at accept time, so a same-cycle commit only affects later beats
  assign y = (raw & ~act_en_q) | (act_en_q & ~act_mode_q & act_val_q) |
             (act_en_q & act_mode_q & (raw ^ act_val_q));
  assign v[0]        = in_valid;
  assign d[0]        = {|(y ^ raw), y};
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    eco_pipe_stage #(.DW(WIDTH + 1)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (v[s]),
      .ready_o (rdy[s]),
      .data_i  (d[s]),
      .valid_o (v[s+1]),
      .ready_i (rdy[s+1]),
      .data_o  (d[s+1])
    );
  end
  assign out_valid        = v[STAGES];
  assign {out_hit, out_y} = d[STAGES];
  // commit reads the pre-write shadow, so a coincident write lands in the shadow only
  assign sh_en_d    = (cfg_wr && cfg_sel == CFG_EN)   ? cfg_data : sh_en_q;
  assign sh_val_d   = (cfg_wr && cfg_sel == CFG_VAL)  ? cfg_data : sh_val_q;
  assign sh_mode_d  = (cfg_wr && cfg_sel == CFG_MODE) ? cfg_data : sh_mode_q;
  assign act_en_d   = cfg_commit ? sh_en_q   : act_en_q;
  assign act_val_d  = cfg_commit ? sh_val_q  : act_val_q;
  assign act_mode_d = cfg_commit ? sh_mode_q : act_mode_q;
  assign hit_cnt_d  = hit_clr ? '0 :
                      (out_valid && out_ready && out_hit && !(&hit_cnt_q)) ? hit_cnt_q + 1'b1 :
                      hit_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en_q    <= '0;
      sh_val_q   <= '0;
      sh_mode_q  <= '0;
      act_en_q   <= '0;
      act_val_q  <= '0;
      act_mode_q <= '0;
      hit_cnt_q  <= '0;
    end else begin
      sh_en_q    <= sh_en_d;
      sh_val_q   <= sh_val_d;
      sh_mode_q  <= sh_mode_d;
      act_en_q   <= act_en_d;
      act_val_q  <= act_val_d;
      act_mode_q <= act_mode_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end
  assign hit_cnt = hit_cnt_q;
endmodule

// File: tb/tb_eco_patch_logic_pipe.sv
// tb_eco_patch_logic_pipe: directed vectors checked against a queue-based reference model
module tb_eco_patch_logic_pipe;
  import eco_pkg::*;
  localparam int W  = 3;
  localparam int S  = 3;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_y, cfg_data;
  logic [2:0]    in_op;
  logic          cfg_wr, cfg_commit, hit_clr;
  logic [1:0]    cfg_sel;
  logic [CW-1:0] hit_cnt;
  always #5 clk = ~clk;
  eco_patch_logic_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .hit_cnt(hit_cnt), .hit_clr(hit_clr)
  );
  int n_cmp = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {logic [W-1:0] y; logic hit;} beat_t;
  beat_t        q[$];
  int           m_cnt = 0;
  int           n_out = 0;
  logic [W-1:0] m_sh_en, m_sh_val, m_sh_mode, m_en, m_val, m_mode;
  function automatic logic [W-1:0] raw_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    logic x, z, r;
    for (int i = 0; i < W; i++) begin
      x = a[i];
      z = b[i];
      case (op)
        3'd0: r = x & z;
        3'd1: r = x | z;
        3'd2: r = !(x & z);
        3'd3: r = !(x | z);
        3'd4: r = x ^ z;
        3'd5: r = (x == z);
        3'd6: r = x;
        default: r = !x;
      endcase
      raw_of[i] = r;
    end
  endfunction
  function automatic logic [W-1:0] patch_of(input logic [W-1:0] r);
    for (int i = 0; i < W; i++)
      patch_of[i] = !m_en[i] ? r[i] : (!m_mode[i] ? m_val[i] : r[i] ^ m_val[i]);
  endfunction
  // reference model: evaluates the handshakes that will occur at the next rising edge
  always @(negedge clk) begin
    logic [W-1:0] r, p;
    logic         pop_hit;
    beat_t        b;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      {m_sh_en, m_sh_val, m_sh_mode, m_en, m_val, m_mode} = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_hit_cnt", hit_cnt, 0);
    end else begin
      chk("hit_cnt", hit_cnt, m_cnt);
      pop_hit = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          chk("out_y", out_y, q[0].y);
          if (out_ready) begin
            pop_hit = q[0].hit;
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (hit_clr) m_cnt = 0;
      else if (pop_hit && m_cnt < 2**CW - 1) m_cnt++;
      if (in_valid && in_ready) begin
        r = raw_of(in_a, in_b, in_op);
        p = patch_of(r);
        b.y = p;
        b.hit = (p != r);
        q.push_back(b);
      end
      if (cfg_commit) {m_en, m_val, m_mode} = {m_sh_en, m_sh_val, m_sh_mode};
      if (cfg_wr && cfg_sel == CFG_EN) m_sh_en = cfg_data;
      if (cfg_wr && cfg_sel == CFG_VAL) m_sh_val = cfg_data;
      if (cfg_wr && cfg_sel == CFG_MODE) m_sh_mode = cfg_data;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [1:0] sel, input logic [W-1:0] dat, input logic commit);
    cfg_wr = 1'b1;
    cfg_sel = sel;
    cfg_data = dat;
    cfg_commit = commit;
    tick();
    cfg_wr = 1'b0;
    cfg_commit = 1'b0;
  endtask
  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask
  task automatic set_patch(input logic [W-1:0] en, input logic [W-1:0] val, input logic [W-1:0] mode);
    cfg(CFG_EN, en, 1'b0);
    cfg(CFG_VAL, val, 1'b0);
    cfg(CFG_MODE, mode, 1'b0);
    commit();
  endtask
  task automatic wait_accept(input string nm);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk({nm, "_accept_timeout"}, in_ready, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_out(input string nm, input logic [W-1:0] exp);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_y"}, out_y, exp);
    tick();
  endtask
  task automatic send_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] exp);
    int lat = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    wait_accept(nm);
    in_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    chk({nm, "_y"}, out_y, exp);
    chk({nm, "_latency"}, lat, S);
    tick();
  endtask
  initial begin
    int n0;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    int n0;
    {in_valid, in_a, in_b, in_op, cfg_wr, cfg_sel, cfg_data, cfg_commit, hit_clr} = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_y", out_y, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();
    // plain logic, patch disabled
    send_one("t1_nor", 3'b000, 3'b000, OP_NOR, 3'b111);
    send_one("t1_xor", 3'b101, 3'b011, OP_XOR, 3'b110);
    chk("t1_hit_cnt", hit_cnt, 0);
    // force bit 1 low
    set_patch(3'b010, 3'b000, 3'b000);
    send_one("t2_force", 3'b000, 3'b000, OP_NOR, 3'b101);
    chk("t2_hit_cnt_a", hit_cnt, 1);
    send_one("t2_nochange", 3'b010, 3'b000, OP_NOR, 3'b101);
    chk("t2_hit_cnt_b", hit_cnt, 1);
    // invert bit 0 on all lanes in xor mode
    set_patch(3'b111, 3'b001, 3'b111);
    send_one("t3_and", 3'b110, 3'b110, OP_AND, 3'b111);
    send_one("t3_pass", 3'b001, 3'b000, OP_PASS_A, 3'b000);
    chk("t3_hit_cnt", hit_cnt, 3);
    // commit coincident with accept of beat A; beat B sees the new set
    cfg(CFG_VAL, 3'b100, 1'b0);
    in_valid = 1'b1;
    in_a = 3'b000;
    in_b = 3'b000;
    in_op = OP_OR;
    cfg_commit = 1'b1;
    chk("t5_in_ready", in_ready, 1);
    tick();
    cfg_commit = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out("t5_beat_a_old", 3'b001);
    wait_out("t5_beat_b_new", 3'b100);
    // write and commit together: commit takes the pre-write shadow
    cfg(CFG_VAL, 3'b110, 1'b0);
    cfg(CFG_VAL, 3'b010, 1'b1);
    send_one("t5_prewrite", 3'b000, 3'b000, OP_OR, 3'b110);
    commit();
    send_one("t5_postwrite", 3'b000, 3'b000, OP_OR, 3'b010);
    chk("t5_hit_cnt", hit_cnt, 7);
    // backpressure stream
    set_patch(3'b101, 3'b100, 3'b001);
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1;
          in_a = W'(i);
          in_b = W'(7 - i);
          in_op = 3'(i);
          wait_accept("t4");
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("t4_in_ready_low", in_ready, 0);
        chk("t4_out_valid_held", out_valid, 1);
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (10) tick();
    chk("t4_beats_out", n_out - n0, 8);
    chk("t4_drained", q.size(), 0);
    // saturation, then clear against a coincident hit
    set_patch(3'b111, 3'b000, 3'b000);
    hit_clr = 1'b1;
    tick();
    hit_clr = 1'b0;
    chk("t6_cleared", hit_cnt, 0);
    in_valid = 1'b1;
    in_a = 3'b000;
    in_b = 3'b000;
    in_op = OP_NOR;
    repeat (20) tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("t6_saturated", hit_cnt, 15);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("t6_hit_beat_present", out_valid, 1);
    hit_clr = 1'b1;
    tick();
    hit_clr = 1'b0;
    chk("t6_clr_priority", hit_cnt, 0);
    // asynchronous reset in the middle of a stream
    in_valid = 1'b1;
    repeat (5) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_hit_cnt", hit_cnt, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    send_one("t6_cfg_lost", 3'b000, 3'b000, OP_NOR, 3'b111);
    chk("t6_post_rst_hit_cnt", hit_cnt, 0);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
